// File: rtl/async_proc_pkg.sv
// Shared types and constants for the operand bank loader and its strobe conditioning.
package async_proc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int SYNC_STAGES = 2;
    localparam int RES_CNT_W   = 8;

endpackage

// File: rtl/strobe_edge_sync.sv
// Synchronises a raw switch strobe and emits a one-cycle pulse on its rising edge.
module strobe_edge_sync
    import async_proc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], strobe_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // prev_q tracks regardless of any enable, so a switch held across a disable never retriggers
    assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/operand_bank_loader.sv
// Operand front end: switch-driven channel loads, commit snapshot offered over valid/ready,
// and capture/count of results returned by the compute block.
module operand_bank_loader
    import async_proc_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = 4,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NCH-1:0]    sel,
    input  logic [IW-1:0]     din,
    input  logic              shift_mode,
    input  logic              commit,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [NCH*DW-1:0] op_data,
    input  logic              res_valid,
    input  logic [DW-1:0]     res_data,
    output logic [DW-1:0]     res_out,
    output logic [7:0]        res_count,
    output logic              overrun
);

    logic [SYNC_STAGES*IW-1:0] din_pipe_q;
    logic [SYNC_STAGES*IW-1:0] din_pipe_d;
    logic [SYNC_STAGES-1:0]    mode_pipe_q;
    logic [SYNC_STAGES-1:0]    mode_pipe_d;
    logic [IW-1:0]             din_s;
    logic                      shift_s;

    logic [NCH-1:0]            sel_rise;
    logic                      commit_rise;
    logic [NCH*DW-1:0]         ch_flat;

    state_t                    state_q;
    state_t                    state_d;
    logic                      op_valid_q;
    logic                      op_valid_d;
    logic [NCH*DW-1:0]         op_data_q;
    logic [NCH*DW-1:0]         op_data_d;
    logic                      overrun_q;
    logic                      overrun_d;
    logic [DW-1:0]             res_out_q;
    logic [DW-1:0]             res_out_d;
    logic [RES_CNT_W-1:0]      res_count_q;
    logic [RES_CNT_W-1:0]      res_count_d;

    // Data path uses plain synchronisers with the same depth as the strobes,
    // so data and its strobe emerge in the same cycle.
    always_comb begin
        din_pipe_d  = {din_pipe_q[(SYNC_STAGES-1)*IW-1:0], din};
        mode_pipe_d = {mode_pipe_q[SYNC_STAGES-2:0], shift_mode};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_pipe_q  <= '0;
            mode_pipe_q <= '0;
        end else begin
            din_pipe_q  <= din_pipe_d;
            mode_pipe_q <= mode_pipe_d;
        end
    end

    assign din_s   = din_pipe_q[SYNC_STAGES*IW-1 -: IW];
    assign shift_s = mode_pipe_q[SYNC_STAGES-1];

    strobe_edge_sync u_commit_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .strobe_in  (commit),
        .rise_pulse (commit_rise)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DW-1:0] ch_q;
            logic [DW-1:0] ch_d;
            logic [DW-1:0] shift_val;

            strobe_edge_sync u_sel_sync (
                .clk        (clk),
                .rst_n      (rst_n),
                .strobe_in  (sel[gi]),
                .rise_pulse (sel_rise[gi])
            );

            if (DW == IW) begin : g_narrow
                assign shift_val = din_s;
            end else begin : g_wide
                assign shift_val = {ch_q[DW-IW-1:0], din_s};
            end

            always_comb begin
                ch_d = ch_q;
                if (ena && sel_rise[gi]) begin
                    ch_d = shift_s ? shift_val : DW'(din_s);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ch_q <= '0;
                end else begin
                    ch_q <= ch_d;
                end
            end

            assign ch_flat[gi*DW +: DW] = ch_q;
        end
    endgenerate

    // Snapshot reads the registered channels, so a same-cycle load is not included.
    always_comb begin
        state_d     = state_q;
        op_valid_d  = op_valid_q;
        op_data_d   = op_data_q;
        overrun_d   = overrun_q;
        res_out_d   = res_out_q;
        res_count_d = res_count_q;

        unique case (state_q)
            IDLE: begin
                if (ena && commit_rise) begin
                    op_data_d  = ch_flat;
                    op_valid_d = 1'b1;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (op_valid_q && op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = IDLE;
                end
                if (ena && commit_rise) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ena && res_valid) begin
            res_out_d   = res_data;
            res_count_d = res_count_q + RES_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_valid_q  <= 1'b0;
            op_data_q   <= '0;
            overrun_q   <= 1'b0;
            res_out_q   <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            op_valid_q  <= op_valid_d;
            op_data_q   <= op_data_d;
            overrun_q   <= overrun_d;
            res_out_q   <= res_out_d;
            res_count_q <= res_count_d;
        end
    end

    assign op_valid  = op_valid_q;
    assign op_data   = op_data_q;
    assign overrun   = overrun_q;
    assign res_out   = res_out_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_operand_bank_loader.sv
// Scoreboard bench: expected snapshots are queued when a commit is issued and checked
// by an independent monitor when the DUT raises op_valid.
module tb_operand_bank_loader;

    localparam int NCH = 4;
    localparam int IW  = 4;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic [NCH-1:0]    sel = '0;
    logic [IW-1:0]     din = '0;
    logic              shift_mode = 1'b0;
    logic              commit = 1'b0;
    logic              op_valid;
    logic              op_ready = 1'b0;
    logic [NCH*DW-1:0] op_data;
    logic              res_valid = 1'b0;
    logic [DW-1:0]     res_data = '0;
    logic [DW-1:0]     res_out;
    logic [7:0]        res_count;
    logic              overrun;

    always #5 clk = ~clk;

    operand_bank_loader #(.NCH(NCH), .IW(IW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sel        (sel),
        .din        (din),
        .shift_mode (shift_mode),
        .commit     (commit),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_data    (op_data),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_out    (res_out),
        .res_count  (res_count),
        .overrun    (overrun)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0]     mch [NCH];
    logic [NCH*DW-1:0] exp_q [$];
    logic              mdl_pending;
    logic              mdl_overrun;
    logic [DW-1:0]     mdl_res_out;
    logic [7:0]        mdl_res_cnt;

    logic              mon_prev = 1'b0;
    logic [NCH*DW-1:0] mon_cur = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) mch[i] = '0;
        exp_q.delete();
        mdl_pending = 1'b0;
        mdl_overrun = 1'b0;
        mdl_res_out = '0;
        mdl_res_cnt = '0;
    endtask

    // Commit is evaluated against the channel contents before any same-cycle load.
    task automatic model_op(input logic [NCH-1:0] m, input logic c, input logic [IW-1:0] d,
                            input logic sm);
        logic [NCH*DW-1:0] snap;
        logic [DW-1:0]     t;
        if (!ena) return;
        if (c) begin
            if (mdl_pending) begin
                mdl_overrun = 1'b1;
            end else begin
                for (int i = 0; i < NCH; i++) snap[i*DW +: DW] = mch[i];
                exp_q.push_back(snap);
                mdl_pending = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) begin
                if (sm) begin
                    t = mch[i] << IW;
                    mch[i] = t | DW'(d);
                end else begin
                    mch[i] = DW'(d);
                end
            end
        end
    endtask

    task automatic do_op(input logic [NCH-1:0] m, input logic c, input logic [IW-1:0] d,
                         input logic sm, input int hold);
        @(negedge clk);
        sel = m; commit = c; din = d; shift_mode = sm;
        model_op(m, c, d, sm);
        repeat (hold) @(negedge clk);
        sel = '0; commit = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_handshake(input string name);
        @(negedge clk);
        op_ready = 1'b1;
        mdl_pending = 1'b0;
        @(negedge clk);
        op_ready = 1'b0;
        check(name, op_valid, 1'b0);
    endtask

    task automatic do_result(input logic [DW-1:0] d);
        @(negedge clk);
        res_valid = 1'b1; res_data = d;
        if (ena) begin
            mdl_res_out = d;
            mdl_res_cnt = mdl_res_cnt + 8'd1;
        end
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_overrun"},  overrun,   mdl_overrun);
        check({tag, "_op_valid"}, op_valid,  mdl_pending);
        check({tag, "_res_out"},  res_out,   mdl_res_out);
        check({tag, "_res_cnt"},  res_count, mdl_res_cnt);
    endtask

    // Monitor: each new offer must match the oldest queued snapshot and stay put while pending.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev = 1'b0;
        end else begin
            if (op_valid && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL offer_unexpected: got op_data %0h expected no offer", op_data);
                end else begin
                    mon_cur = exp_q.pop_front();
                    check("offer_data", op_data, mon_cur);
                end
            end else if (op_valid) begin
                check("offer_stable", op_data, mon_cur);
            end
            mon_prev = op_valid;
        end
    end

    initial begin
        logic [NCH-1:0] m;
        int kind;

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_op_valid", op_valid, 1'b0);
        check("rst_op_data", op_data, '0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_res_out", res_out, '0);
        check("rst_res_count", res_count, '0);
        ena = 1'b1;

        // Held switches load once, in both direct and shift modes
        do_op(4'b0100, 1'b0, 4'h5, 1'b0, 10);
        do_op(4'b0010, 1'b0, 4'h7, 1'b1, 10);
        do_op(4'b0000, 1'b1, 4'h0, 1'b0, 1);
        do_handshake("t1_handshake");
        check_state("t1");

        // Shift-in on ch0, then commit with an exact latency probe
        do_op(4'b0001, 1'b0, 4'hA, 1'b1, 1);
        do_op(4'b0001, 1'b0, 4'h3, 1'b1, 2);
        @(negedge clk);
        commit = 1'b1;
        model_op('0, 1'b1, din, shift_mode);
        @(negedge clk);
        commit = 1'b0;
        check("commit_lat1", op_valid, 1'b0);
        @(negedge clk);
        check("commit_lat2", op_valid, 1'b0);
        @(negedge clk);
        check("commit_lat3", op_valid, 1'b1);
        check("t2_ch0_a3", op_data[7:0], 8'hA3);

        // Pending offer: hold, overrun, load while offering, then release
        repeat (20) @(negedge clk);
        do_op(4'b0000, 1'b1, 4'h0, 1'b0, 1);
        check("t3_overrun", overrun, 1'b1);
        do_op(4'b1000, 1'b0, 4'h9, 1'b0, 1);
        check_state("t3");
        do_handshake("t3_valid_falls");

        // Same-cycle load and commit snapshots the old value; multi-select loads alike
        do_op(4'b0010, 1'b1, 4'hC, 1'b0, 1);
        do_handshake("t4a_handshake");
        do_op(4'b1001, 1'b0, 4'h6, 1'b0, 1);
        do_op(4'b0000, 1'b1, 4'h0, 1'b0, 1);
        do_handshake("t4b_handshake");

        // Load one cycle ahead of the commit must be in the snapshot
        @(negedge clk);
        sel = 4'b0100; din = 4'hE; shift_mode = 1'b0;
        model_op(4'b0100, 1'b0, 4'hE, 1'b0);
        @(negedge clk);
        sel = '0; commit = 1'b1;
        model_op('0, 1'b1, 4'hE, 1'b0);
        @(negedge clk);
        commit = 1'b0;
        repeat (5) @(negedge clk);
        do_handshake("t4c_handshake");
        check_state("t4");

        // Results: 257 pulses wrap the counter, then disabled pulses are ignored
        for (int i = 0; i < 257; i++) do_result(DW'(i));
        @(negedge clk);
        check("t5_res_count", res_count, 8'd1);
        check("t5_res_out", res_out, 8'h00);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) do_result(8'h55);
        @(negedge clk);
        check("t5_dis_count", res_count, 8'd1);
        check("t5_dis_out", res_out, 8'h00);
        ena = 1'b1;

        // Randomised mix of loads, commits, handshakes, results and enable changes
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                m = NCH'($urandom_range(1, (1 << NCH) - 1));
                do_op(m, ($urandom_range(0, 4) == 0), IW'($urandom), $urandom_range(0, 1),
                      $urandom_range(1, 4));
            end else if (kind <= 6) begin
                do_op('0, 1'b1, IW'($urandom), 1'b0, $urandom_range(1, 3));
            end else if (kind == 7) begin
                do_handshake("rnd_handshake");
            end else if (kind == 8) begin
                do_result(DW'($urandom));
            end else begin
                @(negedge clk);
                ena = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            check_state("rnd");
        end
        @(negedge clk);
        ena = 1'b1;
        if (mdl_pending) do_handshake("rnd_final_handshake");
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of an offer
        do_op(4'b0100, 1'b0, 4'hF, 1'b0, 1);
        do_op(4'b0000, 1'b1, 4'h0, 1'b0, 1);
        do_op(4'b0000, 1'b1, 4'h0, 1'b0, 1);
        check_state("t6_pre");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_op_valid", op_valid, 1'b0);
        check("t6_op_data", op_data, '0);
        check("t6_overrun", overrun, 1'b0);
        check("t6_res_count", res_count, '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'b0000, 1'b1, 4'h0, 1'b0, 1);
        check_state("t6_post");
        do_handshake("t6_handshake");
        repeat (2) @(negedge clk);
        check("t6_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
